// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port between NUM_SRC producers.
//   A granted producer may write up to BURST_LEN words. The burst ends early
//   when the producer drops its valid. Writes are held off while wr_full is
//   high. One idle cycle always separates two bursts.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   src_valid  : per-producer word-available flags
//   src_data   : producer lanes, lane i on [i*DATA_W +: DATA_W]
//   src_ack    : per-producer "word written this cycle"
//   grant      : registered one-hot owner of the write port (zero when idle)
//   busy       : registered, high while a burst is in progress
//   wr_full    : FIFO full flag
//   wr_req     : FIFO write request
//   wr_data    : FIFO write data (zero when idle)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int BURST_LEN = 8,
  parameter int DATA_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ack,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      busy,
  input  logic                      wr_full,
  output logic                      wr_req,
  output logic [DATA_W-1:0]         wr_data
);

  localparam int          PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int          CNT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned NSRC  = NUM_SRC;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic               busy_q,  busy_d;
  logic [PTR_W-1:0]   ptr_q,   ptr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic               in_burst;
  logic               owner_valid;
  logic [PTR_W-1:0]   owner_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic               burst_last;
  logic [NUM_SRC-1:0] pick_oh;
  logic               pick_found;

  assign in_burst = (state_q == ST_BURST);

  // grant_q is one-hot, so masking valid with it selects the owner's valid
  assign owner_valid = |(src_valid & grant_q);

  always_comb begin
    owner_idx = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (grant_q[i]) owner_idx = PTR_W'(i);
    end
  end

  always_comb begin
    if (32'(owner_idx) == NSRC - 1) ptr_next = '0;
    else                            ptr_next = owner_idx + PTR_W'(1);
  end

  // Rotating priority: scan indices at/after ptr first, then wrap to the
  // indices below ptr. Two ordered passes avoid a modulo on the index.
  always_comb begin
    pick_oh    = '0;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!pick_found && src_valid[i] && (i >= 32'(ptr_q))) begin
        pick_oh[i] = 1'b1;
        pick_found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!pick_found && src_valid[i] && (i < 32'(ptr_q))) begin
        pick_oh[i] = 1'b1;
        pick_found = 1'b1;
      end
    end
  end

  // rst_n gates the request so a burst interrupted by reset writes nothing
  // in the reset cycle itself
  assign wr_req  = rst_n & in_burst & owner_valid & ~wr_full;
  assign src_ack = grant_q & {NUM_SRC{wr_req}};

  always_comb begin
    wr_data = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (in_burst && grant_q[i]) wr_data = src_data[i*DATA_W +: DATA_W];
    end
  end

  assign burst_last = (cnt_q == CNT_W'(BURST_LEN - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|src_valid) begin
          state_d = ST_BURST;
          grant_d = pick_oh;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        // valid-low exit takes priority over a wr_full stall
        if (!owner_valid || (wr_req && burst_last)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          ptr_d   = ptr_next;
        end else if (wr_req) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Two arbiter instances: dut0 (NUM_SRC=2, BURST_LEN=4) and dut1
//   (NUM_SRC=2, BURST_LEN=1). sel routes the shared stimulus to one of them
//   and the monitored outputs back from it. Producers advance their lane on
//   ack and hold a fixed number of words. Expected writes and grants are
//   queued up front; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic [1:0]  s_valid;
  logic [15:0] s_data;
  logic        s_full;

  logic [1:0] v0, v1;
  logic       f0, f1;
  logic [1:0] ack0, ack1, grant0, grant1;
  logic       busy0, busy1, req0, req1;
  logic [7:0] wd0, wd1;

  assign v0 = sel ? 2'b00 : s_valid;
  assign v1 = sel ? s_valid : 2'b00;
  assign f0 = sel ? 1'b0 : s_full;
  assign f1 = sel ? s_full : 1'b0;

  fifo_wr_arbiter #(.NUM_SRC(2), .BURST_LEN(4), .DATA_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .src_valid(v0), .src_data(s_data),
    .src_ack(ack0), .grant(grant0), .busy(busy0), .wr_full(f0),
    .wr_req(req0), .wr_data(wd0)
  );

  fifo_wr_arbiter #(.NUM_SRC(2), .BURST_LEN(1), .DATA_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .src_valid(v1), .src_data(s_data),
    .src_ack(ack1), .grant(grant1), .busy(busy1), .wr_full(f1),
    .wr_req(req1), .wr_data(wd1)
  );

  logic [1:0] m_ack, m_grant;
  logic       m_busy, m_req;
  logic [7:0] m_wd;
  assign m_ack   = sel ? ack1   : ack0;
  assign m_grant = sel ? grant1 : grant0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_req   = sel ? req1   : req0;
  assign m_wd    = sel ? wd1    : wd0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] lane [2];
  int         rem  [2];
  logic [1:0] mask;

  logic [9:0] exp_wr  [$];
  logic [1:0] exp_gnt [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic inv(input string name, input bit ok, input logic [31:0] val);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: violated at %0t, value 0x%0h", name, $time, val);
    end
  endtask

  task automatic push_wr(input logic [1:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) s_valid[i] = mask[i] && (rem[i] > 0);
    s_data = {lane[1], lane[0]};
  endtask

  // Advance one clock; producers consume words acked in the cycle just ended.
  // Returns 2 ns after the rising edge.
  task automatic tick();
    logic [1:0] a;
    @(negedge clk);
    a = m_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (a[i]) begin
        lane[i] = lane[i] + 8'd1;
        rem[i]  = rem[i] - 1;
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset(input logic which);
    rst_n  = 1'b0;
    sel    = which;
    s_full = 1'b0;
    rem[0] = 0;
    rem[1] = 0;
    lane[0] = 8'h00;
    lane[1] = 8'h00;
    mask   = 2'b11;
    drive();
    tick();
    tick();
    chk("rst_grant",   32'(m_grant), 0);
    chk("rst_busy",    32'(m_busy),  0);
    chk("rst_wr_req",  32'(m_req),   0);
    chk("rst_wr_data", 32'(m_wd),    0);
    chk("rst_src_ack", 32'(m_ack),   0);
    rst_n = 1'b1;
  endtask

  task automatic drained(input string name);
    chk({name, "_writes_left"}, 32'(exp_wr.size()),  0);
    chk({name, "_grants_left"}, 32'(exp_gnt.size()), 0);
  endtask

  // Scoreboard monitor and per-cycle invariants
  logic [1:0] prev_g = 2'b00;
  logic [9:0] e_wr;
  logic [1:0] e_g;

  always @(negedge clk) begin
    inv("inv_grant_onehot", $countones(m_grant) <= 1, 32'(m_grant));
    inv("inv_req_vs_full", !(m_req && (sel ? f1 : f0)), 32'(m_req));
    inv("inv_req_busy", !m_req || m_busy, 32'(m_busy));
    inv("inv_ack_onehot", $countones(m_ack) <= 1, 32'(m_ack));
    inv("inv_ack_needs_req", m_req || (m_ack == 2'b00), 32'(m_ack));
    inv("inv_cnt0", dut0.cnt_q <= 3'd4, 32'(dut0.cnt_q));
    inv("inv_cnt1", dut1.cnt_q <= 1'd1, 32'(dut1.cnt_q));

    if (m_req) begin
      if (exp_wr.size() == 0) begin
        inv("unexpected_write", 1'b0, 32'(m_wd));
      end else begin
        e_wr = exp_wr.pop_front();
        chk("wr_data", 32'(m_wd),  32'(e_wr[7:0]));
        chk("src_ack", 32'(m_ack), 32'(e_wr[9:8]));
      end
    end

    if ((m_grant != prev_g) && (m_grant != 2'b00)) begin
      inv("idle_gap_before_grant", prev_g == 2'b00, 32'(prev_g));
      if (exp_gnt.size() == 0) begin
        inv("unexpected_grant", 1'b0, 32'(m_grant));
      end else begin
        e_g = exp_gnt.pop_front();
        chk("grant_seq", 32'(m_grant), 32'(e_g));
      end
    end
    prev_g = m_grant;
  end

  initial begin
    rst_n   = 1'b0;
    sel     = 1'b0;
    s_full  = 1'b0;
    s_valid = 2'b00;
    s_data  = 16'h0;
    mask    = 2'b11;

    // 1: single producer, 4-word burst, idle cycle, regrant
    do_reset(1'b0);
    for (int n = 0; n < 5; n++) push_wr(2'b01, 8'h10 + 8'(n));
    exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b01);
    lane[0] = 8'h10;
    rem[0]  = 5;
    drive();
    tick();
    chk("t1_grant_latency", 32'(m_grant), 1);
    chk("t1_busy",          32'(m_busy),  1);
    for (int n = 0; n < 4; n++) tick();
    chk("t1_idle_grant",  32'(m_grant), 0);
    chk("t1_idle_wr_req", 32'(m_req),   0);
    tick();
    chk("t1_regrant", 32'(m_grant), 1);
    for (int n = 0; n < 6; n++) tick();
    drained("t1");

    // 2: both producers continuously valid, alternating bursts
    do_reset(1'b0);
    for (int n = 0; n < 4; n++) push_wr(2'b01, 8'hA0 + 8'(n));
    for (int n = 0; n < 4; n++) push_wr(2'b10, 8'hB0 + 8'(n));
    for (int n = 4; n < 8; n++) push_wr(2'b01, 8'hA0 + 8'(n));
    exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10);
    exp_gnt.push_back(2'b01);
    lane[0] = 8'hA0;
    rem[0]  = 8;
    lane[1] = 8'hB0;
    rem[1]  = 4;
    drive();
    for (int n = 0; n < 25; n++) tick();
    drained("t2");

    // 3: wr_full stall for 5 cycles after the 2nd word
    do_reset(1'b0);
    for (int n = 0; n < 4; n++) push_wr(2'b01, 8'h30 + 8'(n));
    exp_gnt.push_back(2'b01);
    lane[0] = 8'h30;
    rem[0]  = 4;
    drive();
    tick();
    tick();
    tick();
    s_full = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall_wr_req", 32'(m_req),       0);
      chk("t3_stall_ack",    32'(m_ack),       0);
      chk("t3_stall_grant",  32'(m_grant),     1);
      chk("t3_stall_cnt",    32'(dut0.cnt_q),  2);
      if (k < 4) tick();
    end
    tick();
    s_full = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    chk("t3_end_grant", 32'(m_grant), 0);
    drained("t3");

    // 4: owner drops valid after 2 words; ptr moves past it
    do_reset(1'b0);
    push_wr(2'b10, 8'h40);
    push_wr(2'b10, 8'h41);
    for (int n = 0; n < 3; n++) push_wr(2'b01, 8'h50 + 8'(n));
    push_wr(2'b10, 8'h42);
    push_wr(2'b10, 8'h43);
    exp_gnt.push_back(2'b10);
    exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10);
    lane[1] = 8'h40;
    rem[1]  = 4;
    drive();
    tick();
    chk("t4_grant_src1", 32'(m_grant), 2);
    lane[0] = 8'h50;
    rem[0]  = 3;
    drive();
    tick();
    tick();
    mask[1] = 1'b0;
    drive();
    tick();
    chk("t4_exit_grant", 32'(m_grant), 0);
    chk("t4_exit_busy",  32'(m_busy),  0);
    mask[1] = 1'b1;
    drive();
    tick();
    chk("t4_next_is_src0", 32'(m_grant), 1);
    for (int n = 0; n < 15; n++) tick();
    drained("t4");

    // 5: reset mid-burst after one word; arbitration restarts at ptr 0
    do_reset(1'b0);
    push_wr(2'b01, 8'h60);
    push_wr(2'b10, 8'h70);
    push_wr(2'b01, 8'h61);
    push_wr(2'b01, 8'h62);
    for (int n = 1; n < 4; n++) push_wr(2'b10, 8'h70 + 8'(n));
    exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10);
    exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10);
    lane[0] = 8'h60;
    rem[0]  = 1;
    lane[1] = 8'h70;
    rem[1]  = 4;
    drive();
    for (int n = 0; n < 5; n++) tick();
    chk("t5_pre_reset_grant", 32'(m_grant), 2);
    rst_n   = 1'b0;
    lane[0] = 8'h61;
    rem[0]  = 2;
    drive();
    #1;
    chk("t5_no_write_in_reset", 32'(m_req), 0);
    tick();
    chk("t5_rst_grant",   32'(m_grant), 0);
    chk("t5_rst_busy",    32'(m_busy),  0);
    chk("t5_rst_wr_req",  32'(m_req),   0);
    chk("t5_rst_wr_data", 32'(m_wd),    0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("t5_restart_src0", 32'(m_grant), 1);
    for (int n = 0; n < 20; n++) tick();
    drained("t5");

    // 6: BURST_LEN=1, wr_full toggling every cycle
    do_reset(1'b1);
    for (int n = 0; n < 3; n++) begin
      push_wr(2'b01, 8'hC0 + 8'(n));
      push_wr(2'b10, 8'hD0 + 8'(n));
      exp_gnt.push_back(2'b01);
      exp_gnt.push_back(2'b10);
    end
    lane[0] = 8'hC0;
    rem[0]  = 3;
    lane[1] = 8'hD0;
    rem[1]  = 3;
    s_full  = 1'b1;
    drive();
    for (int n = 0; n < 40; n++) begin
      tick();
      s_full = ~s_full;
    end
    s_full = 1'b0;
    tick();
    drained("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of an 8-bit IP FIFO between NUM_SRC independent producers. A producer is granted for a burst of up to BURST_LEN words. The arbiter drives the FIFO's wr_req/wr_data and never writes while wr_full is high. It sits between the producer blocks and the FIFO write side.

Parameters:
NUM_SRC, 2, number of producers; legal range 2..4.
BURST_LEN, 8, maximum words accepted per grant; legal range 1..255.
DATA_W, 8, data width; must match the FIFO width.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
src_valid  in  NUM_SRC  bit i high means producer i has a word on its data lane.
src_data  in  NUM_SRC*DATA_W  producer i data on bits [i*DATA_W +: DATA_W].
src_ack  out  NUM_SRC  bit i high means producer i's word is written this cycle; the producer advances its data.
grant  out  NUM_SRC  one-hot owner of the write port; all zeros when idle. Registered.
busy  out  1  high while in the BURST state. Registered.
wr_full  in  1  FIFO full flag.
wr_req  out  1  FIFO write request.
wr_data  out  DATA_W  FIFO write data.

Behaviour:
- States:
  - IDLE: grant = 0. If any src_valid bit is high, choose the first requester at or after index ptr, scanning upward with wrap. On the next edge, register the one-hot grant, clear cnt, and go to BURST. If no src_valid bit is high, stay in IDLE.
  - BURST: the owner g is the bit set in grant.
- Write qualification (combinational, BURST only): wr_req = src_valid[g] & ~wr_full. Outside BURST, wr_req = 0.
- wr_data = src_data lane g when in BURST, else 0. It is a combinational mux.
- src_ack = grant & {NUM_SRC{wr_req}}. At most one bit is high, and only while wr_req is high.
- Arbitration latency: one cycle from src_valid rising in IDLE to grant, and a minimum of one more cycle before the first write.
- Word counter cnt, width clog2(BURST_LEN+1):
  - Increments on each cycle with wr_req high.
  - Holds while wr_full is high or src_valid[g] is low.
- BURST exits to IDLE on the edge where either:
  - wr_req is high and cnt == BURST_LEN-1 (the burst completes), or
  - src_valid[g] is low (the producer has nothing more; any word count is allowed, including zero).
- On exit:
  - grant and busy clear.
  - ptr <= (g+1) mod NUM_SRC.
  - There is always one IDLE cycle between bursts, including when the same producer is granted again.
- wr_full high during BURST: no write, no ack, cnt holds, state holds, grant holds. There is no timeout; the owner keeps the port until the FIFO drains.
- Data is never lost. A word is consumed only when src_ack is high, so the producer holds its data otherwise.
- Simultaneous src_valid[g] low and wr_full high: exit to IDLE (the valid-low rule wins).
- BURST_LEN = 1: every granted write ends the burst.
- Reset (synchronous; applies equally mid-burst):
  - state = IDLE, grant = 0, busy = 0, ptr = 0, cnt = 0.
  - Consequently wr_req = 0, wr_data = 0, src_ack = 0 from the first edge with rst_n low.
  - Any partial burst is abandoned, with no write in the reset cycle.
- Invariants (bench asserts every cycle):
  - grant is one-hot or zero.
  - wr_req & wr_full never both high.
  - wr_req implies busy.
  - popcount(src_ack) <= 1.
  - cnt <= BURST_LEN.

Test Plan:
1. NUM_SRC=2, BURST_LEN=4; only src0 valid, data 0x10,0x11,... advancing on ack -> grant=01 one cycle after valid. wr_req high for exactly 4 consecutive cycles writing 0x10..0x13. Then one IDLE cycle, then a regrant of src0 writing 0x14.
2. Both sources continuously valid (src0 lane 0xA0+n, src1 lane 0xB0+n) -> grants alternate 01,10,01,... Each burst writes 4 words. Sequence: A0..A3, B0..B3, A4..A7, with one idle cycle between bursts.
3. src0 granted; wr_full high for 5 cycles after the 2nd word -> no wr_req and no src_ack during those 5 cycles. cnt holds at 2 and grant stays 01. After wr_full drops, words 3 and 4 are written and the burst ends.
4. src1 granted; src_valid[1] drops after 2 words while src0 is valid -> BURST exits on the valid-low edge. ptr becomes 0 and src0 is granted next. Total words written by src1 = 2.
5. rst_n low for 1 cycle mid-burst (after 1 word) -> on the next edge grant=0, busy=0, wr_req=0, wr_data=0. After release, arbitration restarts from ptr=0.
6. BURST_LEN=1, both sources valid, wr_full toggling every cycle -> exactly one word per grant, alternating sources. No write is ever issued while wr_full is high.
